// File: rtl/mult_booth_seq.sv
// rtl/mult_booth_seq.sv - sequential signed 32x32 radix-4 Booth multiplier with 8-bit CLA add slices
//
// cla_add8 : 8-bit carry-lookahead add slice
//    a, b           8-bit addends
//    cin            carry in
//    sum, cout      8-bit sum, carry out
//
// mult_booth_seq : 16-step radix-4 Booth multiplier controller and operand feeder
//    clock          rising-edge clock
//    reset          synchronous active-high reset
//    data_operandA  multiplicand M (two's complement), sampled on the start edge
//    data_operandB  multiplier Q (two's complement), sampled on the start edge
//    ctrl_MULT      start pulse
//    data_result    product bits [31:0]
//    data_exception product does not fit in 32 signed bits
//    data_resultRDY one-cycle strobe, result and exception valid

module cla_add8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] g;
   logic [7:0] p;
   logic [8:0] c;

   // Each carry is formed straight from generate/propagate terms and cin,
   // so no carry depends on another carry net.
   always_comb begin
      g = a & b;
      p = a ^ b;
      c = '0;
      for (int i = 0; i <= 8; i++) begin
         logic cc;
         cc = cin;
         for (int j = 0; j < i; j++)
            cc = g[j] | (p[j] & cc);
         c[i] = cc;
      end
      sum  = p ^ c[7:0];
      cout = c[8];
   end
endmodule

module mult_booth_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state;
   state_t      state_nxt;

   logic [32:0] acc;
   logic [31:0] q;
   logic        q_m1;
   logic [32:0] m;
   logic [3:0]  cnt;
   logic [31:0] res_q;
   logic        exc_q;

   logic [32:0] opnd;
   logic        sub;
   logic [32:0] addend;
   logic [32:0] sum;
   logic [4:0]  cy;

   logic [32:0] acc_nxt;
   logic [31:0] q_nxt;
   logic        q_m1_nxt;
   logic [32:0] prod_hi;
   logic        exc_nxt;

   // Booth digit select: 0, +-M, +-2M
   always_comb begin
      opnd = '0;
      sub  = 1'b0;
      case ({q[1:0], q_m1})
         3'b001, 3'b010: opnd = m;
         3'b011:         opnd = {m[31:0], 1'b0};
         3'b100: begin
            opnd = {m[31:0], 1'b0};
            sub  = 1'b1;
         end
         3'b101, 3'b110: begin
            opnd = m;
            sub  = 1'b1;
         end
         default:        opnd = '0;
      endcase
      addend = sub ? ~opnd : opnd;
   end

   // 33-bit add: four 8-bit lookahead slices plus the sign bit; carry-out of bit 32 is dropped
   assign cy[0] = sub;
   for (genvar i = 0; i < 4; i++) begin : g_add
      cla_add8 u_add (
         .a    (acc[8*i +: 8]),
         .b    (addend[8*i +: 8]),
         .cin  (cy[i]),
         .sum  (sum[8*i +: 8]),
         .cout (cy[i+1])
      );
   end
   assign sum[32] = acc[32] ^ addend[32] ^ cy[4];

   // Arithmetic shift right by 2 of {sum, q, q_m1}
   assign acc_nxt  = {sum[32], sum[32], sum[32:2]};
   assign q_nxt    = {sum[1:0], q[31:2]};
   assign q_m1_nxt = q[1];

   // Product bits [63:31] must be all equal to fit in 32 signed bits
   assign prod_hi = {acc_nxt[31:0], q_nxt[31]};
   assign exc_nxt = ~((&prod_hi) | ~(|prod_hi));

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      data_resultRDY = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_IDLE;
         S_RUN:  if (cnt == 4'd15) state_nxt = S_DONE;
         S_DONE: begin
            data_resultRDY = 1'b1;
            state_nxt      = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (ctrl_MULT) state_nxt = S_RUN;
   end

   // Result/exception are captured on the final step so they hold through
   // IDLE and through a following operation until its own final step.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         m     <= '0;
         cnt   <= '0;
         res_q <= '0;
         exc_q <= 1'b0;
      end else if (ctrl_MULT) begin
         acc  <= '0;
         q    <= data_operandB;
         q_m1 <= 1'b0;
         m    <= {data_operandA[31], data_operandA};
         cnt  <= '0;
      end else if (state == S_RUN) begin
         acc  <= acc_nxt;
         q    <= q_nxt;
         q_m1 <= q_m1_nxt;
         cnt  <= cnt + 4'd1;
         if (cnt == 4'd15) begin
            res_q <= q_nxt;
            exc_q <= exc_nxt;
         end
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
endmodule

// File: tb/tb_mult_booth_seq.sv
// tb/tb_mult_booth_seq.sv - randomized self-checking bench for mult_booth_seq against a plain-arithmetic model

module tb_mult_booth_seq;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int total = 0;
   int bad   = 0;

   mult_booth_seq dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: full signed product by plain arithmetic; returns {exception, low 32 bits}
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
      longint pa;
      longint pb;
      longint p;
      logic   ex;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      p  = pa * pb;
      ex = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      return {ex, p[31:0]};
   endfunction

   // Called at a negedge: presents a start pulse sampled on the next posedge,
   // returns at the negedge after it with operands scrambled.
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Waits 16 cycles after the start edge; RDY must appear only on the 16th.
   task automatic expect_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input bit hold, input logic [31:0] hold_val);
      logic [32:0] e;
      int early;
      int hold_bad;
      e        = model(a, b);
      early    = 0;
      hold_bad = 0;
      for (int k = 1; k < 16; k++) begin
         @(negedge clock);
         if (data_resultRDY !== 1'b0) early++;
         if (hold && data_result !== hold_val) hold_bad++;
      end
      @(negedge clock);
      chk({tag, "_early_rdy"}, early, 0);
      if (hold) chk({tag, "_hold"}, hold_bad, 0);
      chk({tag, "_rdy"}, data_resultRDY, 1);
      chk({tag, "_result"}, data_result, e[31:0]);
      chk({tag, "_exc"}, data_exception, e[32]);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      launch(a, b);
      expect_done(tag, a, b, 1'b0, '0);
   endtask

   logic [31:0] ra;
   logic [31:0] rb;
   logic [32:0] e1;
   int          rdy_seen;

   initial begin
      repeat (3) @(negedge clock);
      chk("reset_result", data_result, 0);
      chk("reset_exc", data_exception, 0);
      chk("reset_rdy", data_resultRDY, 0);
      reset = 1'b0;
      @(negedge clock);

      run_op("mul_3x5", 32'd3, 32'd5);
      chk("mul_3x5_const", data_result, 32'h0000000F);
      run_op("mul_m7x6", 32'hFFFFFFF9, 32'h00000006);
      chk("mul_m7x6_const", data_result, 32'hFFFFFFD6);
      run_op("ovf_min_x_m1", 32'h80000000, 32'hFFFFFFFF);
      chk("ovf_min_x_m1_exc_const", data_exception, 1);
      run_op("ovf_2p16", 32'h00010000, 32'h00010000);
      chk("ovf_2p16_exc_const", data_exception, 1);
      run_op("min_x_1", 32'h80000000, 32'h00000001);
      chk("min_x_1_exc_const", data_exception, 0);
      run_op("zero", 32'h00000000, 32'h80000000);
      run_op("max_x_max", 32'h7FFFFFFF, 32'h7FFFFFFF);
      run_op("min_x_max", 32'h80000000, 32'h7FFFFFFF);

      // Outputs hold through IDLE
      e1 = model(32'h80000000, 32'h7FFFFFFF);
      repeat (5) @(negedge clock);
      chk("idle_hold_result", data_result, e1[31:0]);
      chk("idle_hold_exc", data_exception, e1[32]);
      chk("idle_rdy", data_resultRDY, 0);

      // Restart mid-run: 3x5 at E0, 2x2 at E8, single RDY after E24
      launch(32'd3, 32'd5);
      repeat (7) @(negedge clock);
      launch(32'd2, 32'd2);
      expect_done("restart", 32'd2, 32'd2, 1'b0, '0);
      chk("restart_const", data_result, 32'd4);

      // Back-to-back: second start in the DONE cycle of the first
      launch(32'd1234567, 32'hFFFFF000);
      expect_done("b2b_first", 32'd1234567, 32'hFFFFF000, 1'b0, '0);
      e1 = model(32'd1234567, 32'hFFFFF000);
      launch(32'hFFFF8001, 32'd77777);
      expect_done("b2b_second", 32'hFFFF8001, 32'd77777, 1'b1, e1[31:0]);

      // Randomized operands (most negative multiplicand excluded)
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 2))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin
               ra = {{16{1'b0}}, 16'($urandom)};
               rb = {{16{1'b0}}, 16'($urandom)};
               ra = $signed(ra[15:0]);
               rb = $signed(rb[15:0]);
            end
            default: begin ra = $urandom; rb = $urandom_range(0, 3) - 2; end
         endcase
         if (ra == 32'h80000000) ra = 32'h80000001;
         run_op($sformatf("rand%0d", n), ra, rb);
      end

      // Reset mid-operation with a simultaneous start: reset wins
      launch(32'd3, 32'd5);
      repeat (4) @(negedge clock);
      reset     = 1'b1;
      ctrl_MULT = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      ctrl_MULT = 1'b0;
      chk("rst_mid_result", data_result, 0);
      chk("rst_mid_exc", data_exception, 0);
      chk("rst_mid_rdy", data_resultRDY, 0);
      rdy_seen = 0;
      for (int k = 6; k <= 30; k++) begin
         @(negedge clock);
         if (data_resultRDY !== 1'b0) rdy_seen++;
      end
      chk("rst_no_rdy", rdy_seen, 0);
      run_op("after_rst", 32'h7FFFFFFF, 32'd2);
      chk("after_rst_const", data_result, 32'hFFFFFFFE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
